// File: rtl/encoder_8to3_serial.sv
// Serial 8-to-3 encoder: emits the index of every set bit of a captured vector, one per beat.
// Latency: first code valid the cycle after capture; one code per cycle while out_ready is held.
// Backpressure: out_ready stalls the held code; in_ready stays low until the final beat retires.
module encoder_8to3_serial #(
    parameter int N         = 8,
    parameter int W         = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [W:0]   count,
    output logic         zero_pulse
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [N-1:0] ONE = 1;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W:0]   count_q, count_d;
    logic         zero_q, zero_d;
    logic [W-1:0] code_sel;
    logic         single;

    function automatic logic [W:0] popcnt(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + (W+1)'(v[i]);
        end
        return c;
    endfunction

    // Last matching index wins, so the loop direction sets the service order.
    always_comb begin
        code_sel = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (pend_q[i]) code_sel = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend_q[i]) code_sel = W'(i);
            end
        end
    end

    assign single = (pend_q != '0) && ((pend_q & (pend_q - ONE)) == '0);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        count_d = count_q;
        zero_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (d != '0) begin
                        pend_d  = d;
                        count_d = popcnt(d);
                        state_d = BUSY;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (out_ready) begin
                    pend_d = pend_q & ~(ONE << code_sel);
                    if (single) begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == BUSY);
    assign out_code   = code_sel;
    assign out_last   = single;
    assign count      = count_q;
    assign zero_pulse = zero_q;

endmodule

// File: tb/tb_encoder_8to3_serial.sv
// Scoreboard bench for encoder_8to3_serial: LSB-first and MSB-first instances.
module tb_encoder_8to3_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d = '0, d2 = '0;
    logic       in_valid = 1'b0, in_valid2 = 1'b0;
    logic       out_ready = 1'b0, out_ready2 = 1'b1;
    logic       in_ready, in_ready2;
    logic [2:0] out_code, out_code2;
    logic       out_valid, out_valid2;
    logic       out_last, out_last2;
    logic [3:0] count, count2;
    logic       zero_pulse, zero_pulse2;

    int total = 0;
    int bad   = 0;
    int beats = 0;
    // entry = {last, count[3:0], code[2:0]}
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];

    always #5 clk = ~clk;

    encoder_8to3_serial #(.N(8), .W(3), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready),
        .out_code(out_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .count(count), .zero_pulse(zero_pulse)
    );

    encoder_8to3_serial #(.N(8), .W(3), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .d(d2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_code(out_code2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2), .count(count2), .zero_pulse(zero_pulse2)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ent(input int code, input int last, input int cnt);
        return {last[0], cnt[3:0], code[2:0]};
    endfunction

    // LSB-first monitor: pops on every accepted beat, checks hold under stall.
    logic       stall_v = 1'b0;
    logic [3:0] stall_val = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v && out_valid)
                chk("stall_hold", {out_last, out_code}, stall_val);
            stall_v   = out_valid && !out_ready;
            stall_val = {out_last, out_code};
            if (out_valid && out_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_code, 8);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("beat_code", out_code, e[2:0]);
                    chk("beat_last", out_last, e[7]);
                    chk("beat_count", count, e[6:3]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready2) begin
            if (exp2_q.size() == 0) begin
                chk("msb_unexpected_beat", out_code2, 8);
            end else begin
                logic [7:0] e;
                e = exp2_q.pop_front();
                chk("msb_code", out_code2, e[2:0]);
                chk("msb_last", out_last2, e[7]);
                chk("msb_count", count2, e[6:3]);
            end
        end
    end

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 1, 0);
        d = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (out_valid && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (cycles >= 50) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int cyc;
        int b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_count", count, 0);
        chk("rst_zero_pulse", zero_pulse, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // single bit 0
        out_ready = 1'b1;
        exp_q.push_back(ent(0, 1, 1));
        send(8'h01);
        chk("t1_count", count, 1);
        @(posedge clk); #1;
        chk("t1_in_ready_back", in_ready, 1);
        chk("t1_count_cleared", count, 0);

        // 1010_0100 -> 2,5,7 back to back
        exp_q.push_back(ent(2, 0, 3));
        exp_q.push_back(ent(5, 0, 3));
        exp_q.push_back(ent(7, 1, 3));
        send(8'hA4);
        wait_idle(cyc);
        chk("t2_busy_cycles", cyc, 3);

        // all ones with out_ready toggling
        for (int i = 0; i < 8; i++) exp_q.push_back(ent(i, (i == 7) ? 1 : 0, 8));
        b0 = beats;
        send(8'hFF);
        chk("t3_count", count, 8);
        cyc = 0;
        while (out_valid && cyc < 60) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            cyc++;
        end
        chk("t3_beats", beats - b0, 8);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // all-zero vector
        send(8'h00);
        chk("t4_zero_pulse", zero_pulse, 1);
        chk("t4_no_valid", out_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("t4_pulse_one_cycle", zero_pulse, 0);

        // reset mid-vector
        exp_q.push_back(ent(0, 0, 2));
        send(8'h81);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("t5_valid_drop", out_valid, 0);
        chk("t5_code_clr", out_code, 0);
        chk("t5_count_clr", count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(ent(4, 1, 1));
        send(8'h10);
        wait_idle(cyc);
        chk("t5_busy_cycles", cyc, 1);

        // new vector offered during BUSY waits for IDLE
        exp_q.push_back(ent(1, 0, 2));
        exp_q.push_back(ent(2, 1, 2));
        exp_q.push_back(ent(3, 0, 2));
        exp_q.push_back(ent(4, 1, 2));
        send(8'h06);
        d = 8'h18;
        in_valid = 1'b1;
        chk("t6_in_ready_busy", in_ready, 0);
        send(8'h18);
        wait_idle(cyc);
        chk("t6_final_count", count, 0);

        // MSB-first instance: 0x81 -> 7 then 0
        exp2_q.push_back(ent(7, 0, 2));
        exp2_q.push_back(ent(0, 1, 2));
        d2 = 8'h81;
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        cyc = 0;
        while ((exp2_q.size() != 0 || exp_q.size() != 0) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("lsb_queue_drained", exp_q.size(), 0);
        chk("msb_queue_drained", exp2_q.size(), 0);
        chk("msb_idle", out_valid2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
